// File: rtl/ddr3_rx_bitslip_trainer.sv
// Read-path word aligner: bit-slips the input deserializer, then steps the input delay line one
// tap at a time, until TRAIN_PATTERN is seen MATCH_COUNT times in a row.
module ddr3_rx_bitslip_trainer #(
   parameter logic [7:0]  TRAIN_PATTERN = 8'hB8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned MATCH_COUNT   = 16,
   parameter int unsigned MAX_TAPS      = 127
) (
   input  logic       fab_clk_i,
   input  logic       arst_ni,
   input  logic       start_i,
   input  logic [7:0] rx_data_i,
   input  logic       delay_line_out_of_range_i,
   output logic       rx_bit_slip_o,
   output logic       delay_line_load_o,
   output logic       delay_line_move_o,
   output logic       delay_line_direction_o,
   output logic       busy_o,
   output logic       locked_o,
   output logic       fail_o,
   output logic [2:0] slip_cnt_o,
   output logic [7:0] tap_cnt_o
);

   localparam int unsigned MatchW  = $clog2(MATCH_COUNT + 1);
   localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [MatchW-1:0]  MatchLast  = MatchW'(MATCH_COUNT - 1);
   localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
   localparam logic [7:0]         TapMax     = 8'(MAX_TAPS);

   typedef enum logic [2:0] {
      StIdle, StLoad, StSettle, StCheck, StSlip, StMove, StLocked, StFail
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          rst_sync_q;
   logic                rst_int_n;
   logic [SettleW-1:0]  settle_q, settle_d;
   logic [MatchW-1:0]   match_q, match_d;
   logic [2:0]          slip_q, slip_d;
   logic [7:0]          tap_q, tap_d;
   logic                slip_pulse_q, slip_pulse_d, load_q, load_d, move_q, move_d;
   logic                dir_q, dir_d, busy_q, busy_d, locked_q, locked_d, fail_q, fail_d;
   logic                match;

   // Assertion is immediate; release takes two clock edges to propagate.
   always_ff @(posedge fab_clk_i or negedge arst_ni) begin
      if (!arst_ni) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign match = (rx_data_i == TRAIN_PATTERN);

   always_ff @(posedge fab_clk_i or negedge rst_int_n) begin
      if (!rst_int_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start_i) state_d = StLoad;
         StLoad:   state_d = StSettle;
         StSettle: if (settle_q == SettleLast) state_d = StCheck;
         StCheck: begin
            if (match) begin
               if (match_q == MatchLast) state_d = StLocked;
            end else if (slip_q == 3'd7) begin
               state_d = StMove;
            end else begin
               state_d = StSlip;
            end
         end
         StSlip:   state_d = StSettle;
         // move_q low means the step was refused on entry to StMove.
         StMove:   state_d = move_q ? StSettle : StFail;
         StLocked: if (start_i) state_d = StLoad;
         StFail:   if (start_i) state_d = StLoad;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      slip_pulse_d = (state_d == StSlip);
      load_d       = (state_d == StLoad);
      move_d       = (state_q == StCheck) && (state_d == StMove) &&
                     !delay_line_out_of_range_i && (tap_q != TapMax);
      dir_d        = (state_d != StIdle);
      busy_d       = state_d inside {StLoad, StSettle, StCheck, StSlip, StMove};
      locked_d     = (state_d == StLocked);
      fail_d       = (state_d == StFail);
   end

   always_comb begin
      settle_d = '0;
      match_d  = match_q;
      slip_d   = slip_q;
      tap_d    = tap_q;
      if (state_q == StSettle) begin
         settle_d = settle_q + 1'b1;
         match_d  = '0;
      end
      if (state_q == StCheck && match) match_d = match_q + 1'b1;
      if (state_d == StLoad) begin
         slip_d = '0;
         tap_d  = '0;
      end
      if (state_q == StCheck && state_d == StSlip) slip_d = slip_q + 1'b1;
      if (move_d) begin
         tap_d  = tap_q + 1'b1;
         slip_d = '0;
      end
   end

   always_ff @(posedge fab_clk_i or negedge rst_int_n) begin
      if (!rst_int_n) begin
         settle_q     <= '0;
         match_q      <= '0;
         slip_q       <= '0;
         tap_q        <= '0;
         slip_pulse_q <= 1'b0;
         load_q       <= 1'b0;
         move_q       <= 1'b0;
         dir_q        <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         settle_q     <= settle_d;
         match_q      <= match_d;
         slip_q       <= slip_d;
         tap_q        <= tap_d;
         slip_pulse_q <= slip_pulse_d;
         load_q       <= load_d;
         move_q       <= move_d;
         dir_q        <= dir_d;
         busy_q       <= busy_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
      end
   end

   assign rx_bit_slip_o          = slip_pulse_q;
   assign delay_line_load_o      = load_q;
   assign delay_line_move_o      = move_q;
   assign delay_line_direction_o = dir_q;
   assign busy_o                 = busy_q;
   assign locked_o               = locked_q;
   assign fail_o                 = fail_q;
   assign slip_cnt_o             = slip_q;
   assign tap_cnt_o              = tap_q;

endmodule

// File: tb/tb_ddr3_rx_bitslip_trainer.sv
// Directed bench for ddr3_rx_bitslip_trainer: reset, aligned lock, slip alignment, tap exhaustion
// to FAIL, and START handling while busy / locked.
module tb_ddr3_rx_bitslip_trainer;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] rx;
   logic       oor;
   logic       slip_o, load_o, move_o, dir_o, busy_o, locked_o, fail_o;
   logic [2:0] slip_cnt;
   logic [7:0] tap_cnt;

   logic       use_rot = 1'b0;
   logic       oor_force = 1'b0;
   logic       oor_arm = 1'b0;
   logic [7:0] fixed_rx = 8'hB8;
   int         offs_init = 0;
   int         slip_base = 0;
   int         move_base = 0;
   int         slips = 0, moves = 0, loads = 0;
   int         checks = 0, errors = 0;

   ddr3_rx_bitslip_trainer dut (
      .fab_clk_i                 (clk),
      .arst_ni                   (arst_n),
      .start_i                   (start),
      .rx_data_i                 (rx),
      .delay_line_out_of_range_i (oor),
      .rx_bit_slip_o             (slip_o),
      .delay_line_load_o         (load_o),
      .delay_line_move_o         (move_o),
      .delay_line_direction_o    (dir_o),
      .busy_o                    (busy_o),
      .locked_o                  (locked_o),
      .fail_o                    (fail_o),
      .slip_cnt_o                (slip_cnt),
      .tap_cnt_o                 (tap_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (slip_o) slips++;
      if (move_o) moves++;
      if (load_o) loads++;
   end

   function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
      return r;
   endfunction

   // Each observed slip pulse undoes one bit of the initial misalignment.
   always_comb begin
      rx = fixed_rx;
      if (use_rot) rx = rotr(8'hB8, (offs_init - (slips - slip_base)) & 7);
   end

   always_comb oor = oor_force | (oor_arm && ((moves - move_base) >= 2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      int l0;
      #12;
      checks++;
      if ({slip_o, load_o, move_o, dir_o, busy_o, locked_o, fail_o, slip_cnt, tap_cnt} !== 18'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0",
                  {slip_o, load_o, move_o, dir_o, busy_o, locked_o, fail_o, slip_cnt, tap_cnt});
      end
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      start  = 1'b1;
      tick();
      checks++;
      if (load_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_sync_edge1 load got %b want 0", load_o);
      end
      tick();
      checks++;
      if (load_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_sync_edge2 load got %b want 0", load_o);
      end
      tick();
      start = 1'b0;
      checks++;
      if (load_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync_start load/busy got %b%b want 11", load_o, busy_o);
      end
      tick();
      tick();
      #3;
      arst_n = 1'b0;
      #1;
      checks++;
      if ({slip_o, load_o, move_o, dir_o, busy_o, locked_o, fail_o, slip_cnt, tap_cnt} !== 18'd0) begin
         errors++;
         $display("FAIL reset_mid_settle got %b want 0",
                  {slip_o, load_o, move_o, dir_o, busy_o, locked_o, fail_o, slip_cnt, tap_cnt});
      end
      l0 = loads + slips + moves;
      tick();
      tick();
      arst_n = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if ((loads + slips + moves) !== l0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pulses pulses got %0d busy %b want %0d busy 0",
                  loads + slips + moves, busy_o, l0);
      end
   endtask

   task automatic test_aligned();
      int s0, m0, l0;
      use_rot  = 1'b0;
      fixed_rx = 8'hB8;
      s0 = slips; m0 = moves; l0 = loads;
      pulse_start();
      checks++;
      if (load_o !== 1'b1 || busy_o !== 1'b1 || dir_o !== 1'b1) begin
         errors++;
         $display("FAIL aligned_cycle1 load/busy/dir got %b%b%b want 111", load_o, busy_o, dir_o);
      end
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (locked_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL aligned_cycle21 locked/busy got %b%b want 01", locked_o, busy_o);
      end
      tick();
      checks++;
      if (locked_o !== 1'b1 || busy_o !== 1'b0 || dir_o !== 1'b1) begin
         errors++;
         $display("FAIL aligned_cycle22 locked/busy/dir got %b%b%b want 101", locked_o, busy_o, dir_o);
      end
      checks++;
      if (slip_cnt !== 3'd0 || tap_cnt !== 8'd0) begin
         errors++;
         $display("FAIL aligned_counts slip %0d tap %0d want 0 0", slip_cnt, tap_cnt);
      end
      checks++;
      if (slips - s0 !== 0 || moves - m0 !== 0 || loads - l0 !== 1) begin
         errors++;
         $display("FAIL aligned_pulses slips %0d moves %0d loads %0d want 0 0 1",
                  slips - s0, moves - m0, loads - l0);
      end
      fixed_rx  = 8'h00;
      oor_force = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (locked_o !== 1'b1 || slips - s0 !== 0 || moves - m0 !== 0) begin
         errors++;
         $display("FAIL locked_ignores_inputs locked %b slips %0d moves %0d want 1 0 0",
                  locked_o, slips - s0, moves - m0);
      end
      fixed_rx  = 8'hB8;
      oor_force = 1'b0;
   endtask

   task automatic test_start_busy();
      int l0;
      l0 = loads;
      pulse_start();
      checks++;
      if (locked_o !== 1'b0 || load_o !== 1'b1) begin
         errors++;
         $display("FAIL relock_start locked/load got %b%b want 01", locked_o, load_o);
      end
      tick();
      pulse_start();
      for (int i = 0; i < 18; i++) tick();
      checks++;
      if (locked_o !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_cycle21 locked got %b want 0", locked_o);
      end
      tick();
      checks++;
      if (locked_o !== 1'b1 || loads - l0 !== 1) begin
         errors++;
         $display("FAIL busy_start_ignored locked %b loads %0d want 1 1", locked_o, loads - l0);
      end
   endtask

   task automatic test_rotated();
      int s0, m0, n;
      s0 = slips; m0 = moves;
      offs_init = 3;
      slip_base = slips;
      use_rot   = 1'b1;
      pulse_start();
      n = 1;
      while (!locked_o && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (locked_o !== 1'b1 || n !== 40) begin
         errors++;
         $display("FAIL rotated_lock locked %b at cycle %0d want 1 at 40", locked_o, n);
      end
      checks++;
      if (slip_cnt !== 3'd3 || tap_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rotated_counts slip %0d tap %0d want 3 0", slip_cnt, tap_cnt);
      end
      checks++;
      if (slips - s0 !== 3 || moves - m0 !== 0) begin
         errors++;
         $display("FAIL rotated_pulses slips %0d moves %0d want 3 0", slips - s0, moves - m0);
      end
   endtask

   task automatic test_never_match();
      int s0, n;
      use_rot   = 1'b0;
      fixed_rx  = 8'h00;
      s0        = slips;
      move_base = moves;
      oor_arm   = 1'b1;
      pulse_start();
      n = 1;
      while (!fail_o && n < 1000) begin
         tick();
         n++;
      end
      checks++;
      if (fail_o !== 1'b1 || busy_o !== 1'b0 || locked_o !== 1'b0) begin
         errors++;
         $display("FAIL never_match_fail fail/busy/locked got %b%b%b want 100",
                  fail_o, busy_o, locked_o);
      end
      checks++;
      if (tap_cnt !== 8'd2 || slip_cnt !== 3'd7) begin
         errors++;
         $display("FAIL never_match_counts tap %0d slip %0d want 2 7", tap_cnt, slip_cnt);
      end
      checks++;
      if (moves - move_base !== 2 || slips - s0 !== 21) begin
         errors++;
         $display("FAIL never_match_pulses moves %0d slips %0d want 2 21",
                  moves - move_base, slips - s0);
      end
      oor_arm  = 1'b0;
      fixed_rx = 8'hB8;
      pulse_start();
      checks++;
      if (fail_o !== 1'b0 || load_o !== 1'b1 || tap_cnt !== 8'd0 || slip_cnt !== 3'd0) begin
         errors++;
         $display("FAIL fail_restart fail %b load %b tap %0d slip %0d want 0 1 0 0",
                  fail_o, load_o, tap_cnt, slip_cnt);
      end
      n = 1;
      while (!locked_o && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (locked_o !== 1'b1 || n !== 22) begin
         errors++;
         $display("FAIL fail_relock locked %b at cycle %0d want 1 at 22", locked_o, n);
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_start_busy();
      test_rotated();
      test_never_match();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_rx_bitslip_trainer.md
DDR3_RX_BITSLIP_TRAINER -- requirements
Module: ddr3_rx_bitslip_trainer

Interface
REQ-001 SHALL have parameter TRAIN_PATTERN, default 8'hB8: expected 4:1 DDR read word (aperiodic under rotation).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: wait cycles after load/slip/move before comparing.
REQ-003 SHALL have parameter MATCH_COUNT, default 16: consecutive matching words needed for lock.
REQ-004 SHALL have parameter MAX_TAPS, default 127: delay-tap limit before fail.
REQ-005 SHALL have port FAB_CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port ARST_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have port START  input  1  single-cycle request to (re)train.
REQ-008 SHALL have port RX_DATA  input  8  deserialized word from input IOD.
REQ-009 SHALL have port DELAY_LINE_OUT_OF_RANGE  input  1  delay line at end of range.
REQ-010 SHALL have port RX_BIT_SLIP  output  1  one-cycle slip pulse to IOD.
REQ-011 SHALL have port DELAY_LINE_LOAD  output  1  one-cycle pulse reloading default delay.
REQ-012 SHALL have port DELAY_LINE_MOVE  output  1  one-cycle pulse stepping delay one tap.
REQ-013 SHALL have port DELAY_LINE_DIRECTION  output  1  step direction, 1 = increment.
REQ-014 SHALL have ports BUSY, LOCKED, FAIL  output  1 each  training active / aligned / aborted.
REQ-015 SHALL have ports SLIP_CNT  output  3  and TAP_CNT  output  8: current slip and tap counts.

Function
REQ-016 SHALL register all outputs; each pulse output SHALL be high exactly during the cycle the FSM occupies the state named below.
REQ-017 SHALL implement states IDLE, LOAD, SETTLE, CHECK, SLIP, MOVE, LOCKED, FAIL.
REQ-018 IDLE: START=1 -> LOAD next cycle; otherwise remain.
REQ-019 LOAD: DELAY_LINE_LOAD=1, SLIP_CNT<=0, TAP_CNT<=0, then -> SETTLE.
REQ-020 SETTLE: hold exactly SETTLE_CYCLES cycles, clear match counter, then -> CHECK.
REQ-021 CHECK: RX_DATA==TRAIN_PATTERN increments match counter; reaching MATCH_COUNT -> LOCKED.
REQ-022 CHECK mismatch: SLIP_CNT<7 -> SLIP; SLIP_CNT==7 -> MOVE.
REQ-023 SLIP: RX_BIT_SLIP=1, SLIP_CNT+1, then -> SETTLE.
REQ-024 MOVE: DELAY_LINE_OUT_OF_RANGE=1 or TAP_CNT==MAX_TAPS -> FAIL with no pulse; else DELAY_LINE_MOVE=1, TAP_CNT+1, SLIP_CNT<=0, -> SETTLE.
REQ-025 DELAY_LINE_DIRECTION SHALL be 1 in all states except IDLE, where it is 0.
REQ-026 BUSY SHALL be 1 in LOAD, SETTLE, CHECK, SLIP, MOVE; START SHALL be ignored while BUSY.
REQ-027 LOCKED SHALL be 1 only in LOCKED; FAIL only in FAIL; SLIP_CNT/TAP_CNT SHALL hold final values there.
REQ-028 START in LOCKED or FAIL SHALL -> LOAD next cycle, dropping LOCKED/FAIL that cycle.
REQ-029 RX_DATA and DELAY_LINE_OUT_OF_RANGE in LOCKED SHALL be ignored.
REQ-030 Counters SHALL never wrap: SLIP_CNT max 7, TAP_CNT max MAX_TAPS.

Reset
REQ-031 ARST_N=0 SHALL immediately force IDLE, all outputs 0, SLIP_CNT=0, TAP_CNT=0, match counter 0, including mid-training.
REQ-032 Reset deassertion SHALL be synchronized internally; first START honoured no earlier than second FAB_CLK edge after release.

Verification
REQ-033 Reset: assert ARST_N=0 mid-SETTLE -> all outputs 0 same cycle, no further pulses until new START.
REQ-034 Aligned: RX_DATA=8'hB8 constant, START at cycle 0 -> DELAY_LINE_LOAD at cycle 1, LOCKED=1 at cycle 22, SLIP_CNT=0, TAP_CNT=0, no slip/move pulses.
REQ-035 Rotated: model rotates RX_DATA per RX_BIT_SLIP, initially 3 slips from 8'hB8 -> exactly 3 RX_BIT_SLIP pulses, LOCKED=1, SLIP_CNT=3.
REQ-036 Never match: RX_DATA=8'h00, OUT_OF_RANGE rises after second MOVE pulse -> 7 slips per tap, 2 DELAY_LINE_MOVE pulses, FAIL=1, TAP_CNT=2.
REQ-037 START while BUSY ignored; START in LOCKED -> LOCKED=0 and DELAY_LINE_LOAD=1 next cycle, relock with RX_DATA=8'hB8.
